// File: rtl/mul_hilo_seq.sv
// mul_hilo_seq: sequential radix-4 Booth multiplier with a HI/LO result pair.
// One Booth step per cycle; MTHI/MTLO-style direct writes while not busy.
// Optional build macro: MUL_HILO_UNSIGNED_EN adds a mul_unsigned input that
// selects a zero-extended (17-step) unsigned multiply.
module mul_hilo_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MUL_HILO_UNSIGNED_EN
  input  logic        mul_unsigned,
`endif
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned DW = 32;       // operand / HI / LO width
  localparam int unsigned AW = 2 * DW;   // accumulator width
  localparam int unsigned BW = DW + 3;   // 34-bit multiplier plus b[-1] guard
  localparam int unsigned CW = 5;        // step counter width

  localparam logic [CW-1:0] LAST_SIGNED   = CW'(15);
  localparam logic [CW-1:0] LAST_UNSIGNED = CW'(16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_mcand;    // multiplicand, pre-shifted by 2i
  logic [BW-1:0] r_mplier;   // multiplier with b[-1]=0 at bit 0, shifted by 2i
  logic [CW-1:0] r_cnt;
  logic          r_uns;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  logic [AW-1:0] w_addend;
  logic [AW-1:0] w_acc_nxt;
  logic          w_accept;
  logic          w_last_step;
  logic          w_start_uns;

`ifdef MUL_HILO_UNSIGNED_EN
  assign w_start_uns = mul_unsigned;
`else
  assign w_start_uns = 1'b0;
`endif

  assign w_accept    = start && (r_state != S_RUN);
  assign w_last_step = (r_cnt == (r_uns ? LAST_UNSIGNED : LAST_SIGNED));
  assign w_acc_nxt   = r_acc + w_addend;

  // Booth triple decode into the 64-bit addend for this step
  always_comb begin
    w_addend = '0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_addend = r_mcand;
      3'b011:         w_addend = r_mcand << 1;
      3'b100:         w_addend = AW'(0) - (r_mcand << 1);
      3'b101, 3'b110: w_addend = AW'(0) - r_mcand;
      default:        w_addend = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last_step) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, Booth accumulation, HI/LO load and direct writes
  always_ff @(posedge clk) begin
    if (clr) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_uns    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 2;
      r_mplier <= r_mplier >> 2;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last_step) begin
        r_hi <= w_acc_nxt[AW-1:DW];
        r_lo <= w_acc_nxt[DW-1:0];
      end
    end else begin
      if (hi_wr) r_hi <= wr_data;
      if (lo_wr) r_lo <= wr_data;
      if (w_accept) begin
        r_acc    <= '0;
        r_cnt    <= '0;
        r_uns    <= w_start_uns;
        r_mcand  <= w_start_uns ? {DW'(0), a} : {{DW{a[DW-1]}}, a};
        r_mplier <= {(w_start_uns ? 2'b00 : {2{b[DW-1]}}), b, 1'b0};
      end
    end
  end

  // Outputs decoded from registers; a pending clr forces them low
  assign busy   = !clr && (r_state == S_RUN);
  assign done   = !clr && (r_state == S_DONE);
  assign hi_out = clr ? DW'(0) : r_hi;
  assign lo_out = clr ? DW'(0) : r_lo;

endmodule

// File: doc/mul_hilo_seq.md
MUL_HILO_SEQ -- requirements
Module: mul_hilo_seq

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 clr  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request multiply of a*b; sampled on rising edge.
REQ-005 a  input  32  multiplicand, two's complement.
REQ-006 b  input  32  multiplier, two's complement.
REQ-007 hi_wr  input  1  direct write of wr_data into HI (MTHI).
REQ-008 lo_wr  input  1  direct write of wr_data into LO (MTLO).
REQ-009 wr_data  input  32  data for hi_wr/lo_wr.
REQ-010 busy  output  1  high while a multiply is in progress; pipeline stall.
REQ-011 done  output  1  one-cycle pulse: HI/LO hold a new product.
REQ-012 hi_out  output  32  HI register, upper 32 bits of product.
REQ-013 lo_out  output  32  LO register, lower 32 bits of product.

Function
REQ-014 FSM states IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE).
REQ-015 IDLE or DONE with start=1: latch a, b; clear 64-bit accumulator and 5-bit step counter; go RUN.
REQ-016 RUN: one radix-4 Booth step per cycle on triple {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0 and i = step counter.
REQ-017 Triple decode: 000/111 add 0; 001/010 add +a; 011 add +2a; 100 add -2a; 101/110 add -a.
REQ-018 Each addend is sign-extended to 64 bits, shifted left by 2i, and added modulo 2^64.
REQ-019 Signed mode takes 16 RUN cycles (i = 0..15).
REQ-020 On the edge ending the last RUN cycle: HI <= acc[63:32], LO <= acc[31:0], go DONE.
REQ-021 Latency: start sampled on edge E0; done high in the cycle after edge E16; HI/LO valid from E16.
REQ-022 DONE lasts exactly one cycle, then IDLE unless start=1, in which case go RUN (back-to-back).
REQ-023 start while in RUN is ignored; latched operands and count are unaffected.
REQ-024 hi_wr/lo_wr in IDLE or DONE update the register on the next edge.
REQ-025 hi_wr/lo_wr in RUN are ignored.
REQ-026 hi_wr/lo_wr together with start in IDLE: write applied, start also accepted; product later overwrites.
REQ-027 a and b may change after the start edge without effect.
REQ-028 hi_out/lo_out hold their value except on a REQ-020 load or a REQ-024 write.

Reset
REQ-029 clr=1 at a rising edge forces IDLE, HI=0, LO=0, accumulator=0, counter=0.
REQ-030 While clr=1: busy=0, done=0, hi_out=0, lo_out=0.
REQ-031 clr overrides start, hi_wr and lo_wr in the same cycle.
REQ-032 clr during RUN aborts the multiply; no done pulse follows.

Configuration
REQ-033 Macro MUL_HILO_UNSIGNED_EN.
REQ-034 Defined: adds input port mul_unsigned (1 bit), sampled with start.
REQ-035 Defined, mul_unsigned=1: operands zero-extended to 34 bits; 17 RUN cycles (i = 0..16); done high in the cycle after E17.
REQ-036 Defined, mul_unsigned=0: behaviour is identical to the signed mode.
REQ-037 Undefined: port is absent; signed operation only.

Verification
REQ-038 a=3, b=5, start at E0 -> busy high for 16 cycles; done in the cycle after E16; HI=0x00000000, LO=0x0000000F.
REQ-039 a=0x7FFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFF, LO=0x80000001; a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-040 a=-1, b=-1 -> HI=0, LO=1; then start (a=2, b=2) in the DONE cycle -> second done 16 cycles later, LO=4.
REQ-041 start again mid-RUN with a=9, b=9, plus lo_wr with wr_data=0xDEAD -> ignored; first product unchanged; exactly one done.
REQ-042 clr at 8th RUN cycle -> next cycle busy=0, HI=LO=0; no done for 20 cycles.
REQ-043 UNSIGNED_EN, mul_unsigned=1, a=b=0xFFFFFFFF -> done in the cycle after E17; HI=0xFFFFFFFE, LO=0x00000001.
